// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop sync, mid-bit sampling, byte out one cycle after the stop sample.
// Backpressure: rx_valid holds the byte until rx_ready; a byte finished while full is dropped and flags overrun.
module uart_rx_core #(
  parameter int unsigned DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          sync1_q, rx_s_q;
  logic          deliver;
  logic          handshake;

  // Synchronizer flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          // Right shift so that after eight samples bit 0 holds the first (LSB) bit.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign handshake = valid_q & rx_ready;

  // A handshake in the same cycle as a delivery frees the slot, so the new byte loads without overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
